motor_duty_mixer: RTL and testbench



---
 rtl/motor_duty_mixer_pkg.sv | 28 ++
 rtl/motor_duty_mixer_if.sv | 25 ++
 rtl/motor_duty_mixer_duty_scaler.sv | 73 +++++++
 rtl/motor_duty_mixer.sv | 134 +++++++++++++
 tb/tb_motor_duty_mixer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/motor_duty_mixer_pkg.sv
// Shared types and default constants for the motor duty mixer.
// Holds the drive-state enum, duty word width and the absolute-value helper.
package motor_duty_mixer_pkg;

   localparam int DUTY_W          = 32;
   localparam int DEF_SHIFT       = 15;
   localparam int DEF_DUTY_MAX    = 9999;
   localparam int DEF_DUTY_MIN    = 1;
   localparam int DEF_DEAD_CYCLES = 100;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_FWD  = 2'd1,
      ST_REV  = 2'd2,
      ST_DEAD = 2'd3
   } mix_state_e;

   // Magnitude of a 33-bit two's-complement value; the most negative
   // reachable difference is -(2^32-1), so the result never overflows.
   function automatic logic [32:0] abs33(input logic [32:0] v);
      if (v[32]) begin
         abs33 = 33'd0 - v;
      end else begin
         abs33 = v;
      end
   endfunction

endpackage

// File: rtl/motor_duty_mixer_if.sv
// Bus between the PID loops / PWM block and the duty mixer.
// The master side drives the loop outputs and enable; the slave produces duties.
interface motor_duty_mixer_if;
   import motor_duty_mixer_pkg::*;

   logic                     Enable;
   logic signed [31:0]       PID_A_In;
   logic signed [31:0]       PID_B_In;
   logic [DUTY_W-1:0]        CH0_duty_Set;
   logic [DUTY_W-1:0]        CH1_duty_Set;
   logic                     Dir;
   logic                     Dead;
   logic                     Sat;

   modport master (
      output Enable, PID_A_In, PID_B_In,
      input  CH0_duty_Set, CH1_duty_Set, Dir, Dead, Sat
   );

   modport slave (
      input  Enable, PID_A_In, PID_B_In,
      output CH0_duty_Set, CH1_duty_Set, Dir, Dead, Sat
   );

endinterface

// File: rtl/motor_duty_mixer_duty_scaler.sv
// Two-stage pipeline: registered 33-bit loop difference, then sign,
// shifted magnitude clamped to the duty range and a saturation flag.
module motor_duty_mixer_duty_scaler
   import motor_duty_mixer_pkg::*;
#(
   parameter int SHIFT    = DEF_SHIFT,
   parameter int DUTY_MAX = DEF_DUTY_MAX,
   parameter int DUTY_MIN = DEF_DUTY_MIN
) (
   input  logic                CLK,
   input  logic                RST_n,
   input  logic signed [31:0]  pid_a,
   input  logic signed [31:0]  pid_b,
   output logic                neg,
   output logic [DUTY_W-1:0]   duty,
   output logic                sat
);

   localparam logic [32:0] MAX33 = 33'(DUTY_MAX);
   localparam logic [32:0] MIN33 = 33'(DUTY_MIN);

   logic signed [32:0]  diff_r;
   logic [32:0]         mag_s;
   logic [32:0]         scaled_s;
   logic [DUTY_W-1:0]   duty_s;
   logic                sat_s;
   logic                neg_r;
   logic [DUTY_W-1:0]   duty_r;
   logic                sat_r;

   // Stage 1: widen before subtracting so no 32-bit input pair can wrap.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         diff_r <= 33'sd0;
      end else begin
         diff_r <= $signed({pid_a[31], pid_a}) - $signed({pid_b[31], pid_b});
      end
   end

   // Magnitude, scaling and clamp for stage 2.
   always_comb begin
      mag_s    = abs33(diff_r);
      scaled_s = mag_s >> SHIFT;
      sat_s    = 1'b0;
      duty_s   = DUTY_W'(DUTY_MIN);
      if (scaled_s > MAX33) begin
         duty_s = DUTY_W'(DUTY_MAX);
         sat_s  = 1'b1;
      end else if (scaled_s < MIN33) begin
         duty_s = DUTY_W'(DUTY_MIN);
      end else begin
         duty_s = scaled_s[DUTY_W-1:0];
      end
   end

   // Stage 2 register; reset state matches a zero difference.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         neg_r  <= 1'b0;
         duty_r <= DUTY_W'(DUTY_MIN);
         sat_r  <= 1'b0;
      end else begin
         neg_r  <= diff_r[32];
         duty_r <= duty_s;
         sat_r  <= sat_s;
      end
   end

   assign neg  = neg_r;
   assign duty = duty_r;
   assign sat  = sat_r;

endmodule

// File: rtl/motor_duty_mixer.sv
// Drive-direction FSM with dead interval on reversal; turns the scaled
// loop difference into registered H-bridge CH0/CH1 duty words.
module motor_duty_mixer
   import motor_duty_mixer_pkg::*;
#(
   parameter int SHIFT       = DEF_SHIFT,
   parameter int DUTY_MAX    = DEF_DUTY_MAX,
   parameter int DUTY_MIN    = DEF_DUTY_MIN,
   parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   motor_duty_mixer_if.slave    bus
);

   localparam logic [DUTY_W-1:0] DMIN      = DUTY_W'(DUTY_MIN);
   localparam logic [31:0]       DEAD_LOAD = 32'(DEAD_CYCLES - 1);

   logic                neg_s;
   logic [DUTY_W-1:0]   duty_s;
   logic                sat_s;

   mix_state_e          state_r, next_state_s;
   logic [31:0]         cnt_r, cnt_next_s;
   logic [DUTY_W-1:0]   ch0_r, ch1_r, ch0_next_s, ch1_next_s;
   logic                dir_r, dead_r, sat_r;
   logic                dir_next_s, dead_next_s, sat_next_s;

   motor_duty_mixer_duty_scaler #(
      .SHIFT    (SHIFT),
      .DUTY_MAX (DUTY_MAX),
      .DUTY_MIN (DUTY_MIN)
   ) u_scaler (
      .CLK   (CLK),
      .RST_n (RST_n),
      .pid_a (bus.PID_A_In),
      .pid_b (bus.PID_B_In),
      .neg   (neg_s),
      .duty  (duty_s),
      .sat   (sat_s)
   );

   // Next state, dead counter and the output values for that next state.
   always_comb begin
      next_state_s = state_r;
      cnt_next_s   = cnt_r;
      dir_next_s   = dir_r;
      ch0_next_s   = DMIN;
      ch1_next_s   = DMIN;
      dead_next_s  = 1'b0;
      sat_next_s   = 1'b0;

      if (!bus.Enable) begin
         next_state_s = ST_STOP;
         cnt_next_s   = 32'd0;
      end else begin
         case (state_r)
            ST_STOP: next_state_s = neg_s ? ST_REV : ST_FWD;
            ST_FWD: begin
               if (neg_s) begin
                  next_state_s = ST_DEAD;
                  cnt_next_s   = DEAD_LOAD;
               end else begin
                  next_state_s = ST_FWD;
               end
            end
            ST_REV: begin
               if (!neg_s) begin
                  next_state_s = ST_DEAD;
                  cnt_next_s   = DEAD_LOAD;
               end else begin
                  next_state_s = ST_REV;
               end
            end
            ST_DEAD: begin
               if (cnt_r == 32'd0) begin
                  next_state_s = neg_s ? ST_REV : ST_FWD;
               end else begin
                  next_state_s = ST_DEAD;
                  cnt_next_s   = cnt_r - 32'd1;
               end
            end
            default: begin
               next_state_s = ST_STOP;
               cnt_next_s   = 32'd0;
            end
         endcase
      end

      // Dir is left untouched in DEAD so it still shows the old direction.
      case (next_state_s)
         ST_FWD: begin
            ch0_next_s = duty_s;
            dir_next_s = 1'b0;
            sat_next_s = sat_s;
         end
         ST_REV: begin
            ch1_next_s = duty_s;
            dir_next_s = 1'b1;
            sat_next_s = sat_s;
         end
         ST_DEAD: dead_next_s = 1'b1;
         default: dir_next_s = 1'b0;
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state_r <= ST_STOP;
         cnt_r   <= 32'd0;
         ch0_r   <= DMIN;
         ch1_r   <= DMIN;
         dir_r   <= 1'b0;
         dead_r  <= 1'b0;
         sat_r   <= 1'b0;
      end else begin
         state_r <= next_state_s;
         cnt_r   <= cnt_next_s;
         ch0_r   <= ch0_next_s;
         ch1_r   <= ch1_next_s;
         dir_r   <= dir_next_s;
         dead_r  <= dead_next_s;
         sat_r   <= sat_next_s;
      end
   end

   assign bus.CH0_duty_Set = ch0_r;
   assign bus.CH1_duty_Set = ch1_r;
   assign bus.Dir          = dir_r;
   assign bus.Dead         = dead_r;
   assign bus.Sat          = sat_r;

endmodule

// File: tb/tb_motor_duty_mixer.sv
// Bench for motor_duty_mixer: directed scenarios plus randomized inputs,
// every cycle compared against a cycle-level behavioural model.
module tb_motor_duty_mixer;

   localparam int SHIFT    = 15;
   localparam int DUTY_MAX = 9999;
   localparam int DUTY_MIN = 1;
   localparam int DEAD_CYC = 4;

   localparam int M_STOP = 0;
   localparam int M_FWD  = 1;
   localparam int M_REV  = 2;
   localparam int M_DEAD = 3;

   logic CLK = 1'b0;
   logic RST_n;

   motor_duty_mixer_if bus ();

   motor_duty_mixer #(
      .SHIFT       (SHIFT),
      .DUTY_MAX    (DUTY_MAX),
      .DUTY_MIN    (DUTY_MIN),
      .DEAD_CYCLES (DEAD_CYC)
   ) dut (
      .CLK   (CLK),
      .RST_n (RST_n),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // model state: last difference, stage-2 view of it, drive mode
   longint m_d1;
   bit     m_neg, m_sat;
   longint m_duty;
   int     m_mode, m_dead_left;
   longint e_ch0, e_ch1;
   bit     e_dir, e_dead, e_sat;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_edge();
      longint mag, scaled;
      if (!RST_n) begin
         m_d1 = 0; m_neg = 1'b0; m_duty = DUTY_MIN; m_sat = 1'b0;
         m_mode = M_STOP; m_dead_left = 0; e_dir = 1'b0;
         e_ch0 = DUTY_MIN; e_ch1 = DUTY_MIN; e_dead = 1'b0; e_sat = 1'b0;
      end else begin
         if (!bus.Enable) m_mode = M_STOP;
         else if (m_mode == M_STOP) m_mode = m_neg ? M_REV : M_FWD;
         else if (m_mode == M_FWD && m_neg) begin m_mode = M_DEAD; m_dead_left = DEAD_CYC; end
         else if (m_mode == M_REV && !m_neg) begin m_mode = M_DEAD; m_dead_left = DEAD_CYC; end
         else if (m_mode == M_DEAD) begin
            m_dead_left--;
            if (m_dead_left == 0) m_mode = m_neg ? M_REV : M_FWD;
         end
         e_ch0  = (m_mode == M_FWD) ? m_duty : DUTY_MIN;
         e_ch1  = (m_mode == M_REV) ? m_duty : DUTY_MIN;
         e_dead = (m_mode == M_DEAD);
         e_sat  = (m_mode == M_FWD || m_mode == M_REV) ? m_sat : 1'b0;
         if (m_mode != M_DEAD) e_dir = (m_mode == M_REV);
         mag    = (m_d1 < 0) ? -m_d1 : m_d1;
         scaled = mag / (longint'(1) << SHIFT);
         m_neg  = (m_d1 < 0);
         m_sat  = (scaled > DUTY_MAX);
         m_duty = (scaled > DUTY_MAX) ? DUTY_MAX : ((scaled < DUTY_MIN) ? DUTY_MIN : scaled);
         m_d1   = longint'(bus.PID_A_In) - longint'(bus.PID_B_In);
      end
   endtask

   task automatic drive(input bit en, input logic [31:0] a, input logic [31:0] b);
      bus.Enable   = en;
      bus.PID_A_In = a;
      bus.PID_B_In = b;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         model_edge();
         #1;
         chk_eq("ch0",  bus.CH0_duty_Set, 32'(e_ch0));
         chk_eq("ch1",  bus.CH1_duty_Set, 32'(e_ch1));
         chk_eq("dir",  {31'd0, bus.Dir},  {31'd0, e_dir});
         chk_eq("dead", {31'd0, bus.Dead}, {31'd0, e_dead});
         chk_eq("sat",  {31'd0, bus.Sat},  {31'd0, e_sat});
      end
   endtask

   initial begin
      int dead_cnt;
      int guard;
      RST_n = 1'b0;
      drive(1'b0, 32'd0, 32'd0);
      step(2);
      chk_eq("rst_ch0", bus.CH0_duty_Set, 32'd1);
      chk_eq("rst_dead", {31'd0, bus.Dead}, 32'd0);
      RST_n = 1'b1;

      drive(1'b1, 32'd16384000, 32'd0);
      step(3);
      chk_eq("fwd500_ch0", bus.CH0_duty_Set, 32'd500);
      chk_eq("fwd500_ch1", bus.CH1_duty_Set, 32'd1);

      drive(1'b1, 32'd327680000, 32'd0);
      step(3);
      chk_eq("satfwd_ch0", bus.CH0_duty_Set, 32'd9999);
      chk_eq("satfwd_sat", {31'd0, bus.Sat}, 32'd1);

      drive(1'b1, 32'd0, 32'd0);
      step(3);
      chk_eq("zero_ch0", bus.CH0_duty_Set, 32'd1);

      drive(1'b1, 32'd16384000, 32'd0);
      step(3);
      drive(1'b1, 32'd0, 32'd32768000);
      dead_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (bus.Dead) dead_cnt++;
      end
      chk_eq("rev_dead_len", 32'(dead_cnt), 32'd4);
      chk_eq("rev_ch1", bus.CH1_duty_Set, 32'd1000);
      chk_eq("rev_dir", {31'd0, bus.Dir}, 32'd1);

      drive(1'b1, 32'h7FFFFFFF, 32'h80000000);
      step(10);
      chk_eq("wide_fwd_ch0", bus.CH0_duty_Set, 32'd9999);
      chk_eq("wide_fwd_sat", {31'd0, bus.Sat}, 32'd1);
      drive(1'b1, 32'h80000000, 32'h7FFFFFFF);
      step(10);
      chk_eq("wide_rev_ch1", bus.CH1_duty_Set, 32'd9999);

      // drop Enable on the second dead cycle of a REV->FWD reversal
      drive(1'b1, 32'h7FFFFFFF, 32'h80000000);
      guard = 0;
      do begin
         step(1);
         guard++;
      end while (!bus.Dead && guard < 10);
      chk_eq("dead_seen", {31'd0, bus.Dead}, 32'd1);
      step(1);
      drive(1'b0, 32'h7FFFFFFF, 32'h80000000);
      step(1);
      chk_eq("off_dead", {31'd0, bus.Dead}, 32'd0);
      chk_eq("off_ch0", bus.CH0_duty_Set, 32'd1);
      drive(1'b0, 32'd0, 32'd32768000);
      step(3);
      drive(1'b1, 32'd0, 32'd32768000);
      step(1);
      chk_eq("on_rev_dir", {31'd0, bus.Dir}, 32'd1);
      chk_eq("on_rev_dead", {31'd0, bus.Dead}, 32'd0);
      chk_eq("on_rev_ch1", bus.CH1_duty_Set, 32'd1000);

      RST_n = 1'b0;
      step(1);
      RST_n = 1'b1;
      chk_eq("rst_rev_ch1", bus.CH1_duty_Set, 32'd1);
      chk_eq("rst_rev_dir", {31'd0, bus.Dir}, 32'd0);

      for (int i = 0; i < 600; i++) begin
         logic [31:0] a, b;
         bit en;
         en = bus.Enable;
         if ($urandom_range(0, 24) == 0) en = ~en;
         a = bus.PID_A_In;
         b = bus.PID_B_In;
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               a = $urandom;
               b = $urandom;
            end else begin
               a = 32'($signed($urandom_range(0, 800000000)) - 400000000);
               b = 32'($signed($urandom_range(0, 800000000)) - 400000000);
            end
         end
         RST_n = ($urandom_range(0, 99) != 0);
         drive(en, a, b);
         step(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
